score_tracker: RTL and testbench
================================

# score_tracker

Sits directly downstream of `hit_detector`. Consumes its `hit` level and the playfield's note-advance pulse, and keeps the game's running statistics:
- BCD score with combo multiplier,
- current and best combo,
- miss count,
- game-over status.

It replaces the ad-hoc `posedge hit` score counter in `playlogic`. Outputs feed `hex_decoder` instances and the animation modules.

## Interface
Parameters:
- `FLASH_CYCLES`, 24'd2500000 — `hit_flash` pulse length in clocks.
- `MAX_MISSES`, 4'd8 — miss count that ends the game.
- `COMBO_T1`, 8'd4 — combo at or above this gives ×2.
- `COMBO_T2`, 8'd8 — combo at or above this gives ×3.
- `COMBO_T3`, 8'd16 — combo at or above this gives ×4.

Ports (one clock `clk`; reset `reset_b` is asynchronous, active-low):
- `clk` in 1 — system clock (CLOCK_50 domain).
- `reset_b` in 1 — asynchronous active-low reset.
- `start` in 1 — level/pulse; starts or restarts a game.
- `hit` in 1 — level from `hit_detector`; may stay high several cycles.
- `note_pass` in 1 — one-cycle pulse when the current note leaves the hit window (`updateline`).
- `done` in 1 — stream exhausted; ends the game.
- `score_bcd` out 12 — three BCD digits [11:8] hundreds, [7:4] tens, [3:0] ones.
- `combo` out 8 — consecutive hits, saturating at 255.
- `best_combo` out 8 — maximum `combo` this game.
- `mult` out 3 — current multiplier, 1..4.
- `miss_count` out 4 — misses this game.
- `game_over` out 1 — high in OVER.
- `hit_flash` out 1 — high for FLASH_CYCLES after each scored hit.

## Operation
- **States:** IDLE, PLAY, OVER.
  - IDLE → PLAY on `start`.
  - PLAY → OVER when `done`=1, or when `miss_count` reaches MAX_MISSES.
  - OVER → PLAY on `start`.
  - `start` in PLAY restarts the game.
- **Entering PLAY:** clears `score_bcd`, `combo`, `best_combo`, `miss_count`, pending credit and the flash timer. Sets `armed`=1.
- **Hit edge:** `hit` sampled 1 while the previous sample was 0. Only edges in PLAY with `armed`=1 score.
- **Scored hit:**
  - `armed`←0.
  - `combo`←`combo`+1, saturating at 255.
  - `best_combo`←max(`best_combo`, new combo).
  - pending←pending+mult(new combo), saturating at 15.
  - Flash timer loads FLASH_CYCLES.
- A hit edge with `armed`=0 (second hit on the same note) is ignored.
- **Note pass:** `note_pass` in PLAY with `armed`=1 is a miss: `combo`←0, `miss_count`+1. Then `armed`←1 regardless.
- **mult:** 1 if combo<T1; 2 if <T2; 3 if <T3; else 4. Combinational from the `combo` register.
- **Score drain:** while pending≠0 in PLAY or OVER, `score_bcd` increments by 1 per cycle and pending decrements. `score_bcd` saturates at 999; pending still drains.
- IDLE and OVER ignore `hit` and `note_pass`.

## Timing
- Reset value of every output and register is 0: `score_bcd`=0, `combo`=0, `best_combo`=0, `mult`=1 (derived), `miss_count`=0, `game_over`=0, `hit_flash`=0, state IDLE, `armed`=0.
- Hit edge sampled at edge N: `combo`/pending updated at N; first score increment visible at N+1; a ×k hit completes by N+k.
- `hit_flash` rises at N and is high for exactly FLASH_CYCLES cycles.
- Hit edge and `note_pass` in the same cycle: the hit scores for the current note, no miss, and `armed` ends at 1.
- Pending load and drain in the same cycle: pending←pending−1+mult.
- `done` and `start` in the same cycle: `start` wins (restart).
- The miss that makes `miss_count`=MAX_MISSES enters OVER on the next edge.
- Async reset mid-drain discards pending credit.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, PLAY=1, OVER=2),
  - default combo thresholds,
  - BCD digit width constant.
- One sub-module, `bcd_inc3`: a combinational 3-digit BCD +1 that saturates at 999. The drain logic instantiates it.
- Score digits drive existing `hex_decoder` instances at top level.

## Test plan
- Reset, `start` pulse, 3 isolated hit edges each followed by `note_pass` → `score_bcd`=003, `combo`=3, `miss_count`=0.
- 5 consecutive scored hits → `score_bcd`=1+1+1+2+2=007, `mult`=2, `best_combo`=5; then one `note_pass` without hit → `combo`=0, `best_combo`=5, `miss_count`=1.
- `hit` held high 10 cycles, then a second edge before `note_pass` → only one hit scored (`combo`=1).
- Hit edge and `note_pass` in the same cycle → `combo` increments, `miss_count` unchanged.
- 8 unhit `note_pass` pulses → `game_over`=1 on the edge after the 8th; further hit edges leave `score_bcd` unchanged.
- Preload `score_bcd` near 998 via repeated ×4 hits → saturates at 999. Assert `reset_b`=0 mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/score_tracker_pkg.sv
// Shared types and constants for the score tracker: FSM encoding, default
// combo thresholds, BCD widths and the combo-to-multiplier mapping.
package score_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [7:0] DEF_COMBO_T1 = 8'd4;
    localparam logic [7:0] DEF_COMBO_T2 = 8'd8;
    localparam logic [7:0] DEF_COMBO_T3 = 8'd16;

    localparam int BCD_DIGIT_W = 4;
    localparam int SCORE_W     = 3 * BCD_DIGIT_W;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 12'h999;

    // Multiplier grows one step at each threshold crossed; thresholds are ascending.
    function automatic logic [2:0] mult_of(input logic [7:0] combo,
                                           input logic [7:0] t1,
                                           input logic [7:0] t2,
                                           input logic [7:0] t3);
        logic [2:0] m;
        if (combo < t1)      m = 3'd1;
        else if (combo < t2) m = 3'd2;
        else if (combo < t3) m = 3'd3;
        else                 m = 3'd4;
        return m;
    endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Bundle of game-event inputs and statistics outputs between the playfield
// logic (master) and the score tracker (slave).
interface score_tracker_if;
    import score_tracker_pkg::*;

    logic               start;
    logic               hit;
    logic               note_pass;
    logic               done;
    logic [SCORE_W-1:0] score_bcd;
    logic [7:0]         combo;
    logic [7:0]         best_combo;
    logic [2:0]         mult;
    logic [3:0]         miss_count;
    logic               game_over;
    logic               hit_flash;

    modport master (
        output start, hit, note_pass, done,
        input  score_bcd, combo, best_combo, mult, miss_count, game_over, hit_flash
    );

    modport slave (
        input  start, hit, note_pass, done,
        output score_bcd, combo, best_combo, mult, miss_count, game_over, hit_flash
    );

endinterface

// File: rtl/score_tracker_bcd_inc3.sv
// Combinational three-digit BCD increment that holds at 999 instead of
// wrapping, so the score display never rolls over.
module bcd_inc3
    import score_tracker_pkg::*;
(
    input  logic [SCORE_W-1:0] value_i,
    output logic [SCORE_W-1:0] value_o
);

    logic [BCD_DIGIT_W-1:0] ones;
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] hundreds;

    always_comb begin
        ones     = value_i[BCD_DIGIT_W-1:0];
        tens     = value_i[2*BCD_DIGIT_W-1:BCD_DIGIT_W];
        hundreds = value_i[3*BCD_DIGIT_W-1:2*BCD_DIGIT_W];
        value_o  = value_i;
        if (value_i != SCORE_MAX) begin
            if (ones == 4'd9) begin
                ones = 4'd0;
                if (tens == 4'd9) begin
                    tens     = 4'd0;
                    hundreds = hundreds + 4'd1;
                end else begin
                    tens = tens + 4'd1;
                end
            end else begin
                ones = ones + 4'd1;
            end
            value_o = {hundreds, tens, ones};
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Running game statistics: BCD score with combo multiplier, combo/best combo,
// misses and game-over status, fed by hit_detector and the note-advance pulse.
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter logic [23:0] FLASH_CYCLES = 24'd2500000,
    parameter logic [3:0]  MAX_MISSES   = 4'd8,
    parameter logic [7:0]  COMBO_T1     = DEF_COMBO_T1,
    parameter logic [7:0]  COMBO_T2     = DEF_COMBO_T2,
    parameter logic [7:0]  COMBO_T3     = DEF_COMBO_T3
)(
    input  logic            clk,
    input  logic            reset_b,
    score_tracker_if.slave  bus
);

    state_t             state_q, state_d;
    logic               hit_prev_q;
    logic               armed_q, armed_d;
    logic [7:0]         combo_q, combo_d;
    logic [7:0]         best_q, best_d;
    logic [3:0]         miss_q, miss_d;
    logic [3:0]         pending_q, pending_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [23:0]        flash_q, flash_d;

    logic               in_play;
    logic               hit_edge;
    logic               scored;
    logic               missed;
    logic               drain;
    logic [7:0]         combo_next;
    logic [2:0]         mult_new;
    logic [4:0]         pend_add;
    logic [4:0]         pend_sum;
    logic [SCORE_W-1:0] score_inc;

    bcd_inc3 u_inc (
        .value_i (score_q),
        .value_o (score_inc)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // start from any state (re)enters PLAY and beats a simultaneous done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = PLAY;
            PLAY: begin
                if (bus.start)                    state_d = PLAY;
                else if (bus.done)                state_d = OVER;
                else if (miss_q >= MAX_MISSES)    state_d = OVER;
            end
            OVER: if (bus.start) state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.game_over = (state_q == OVER);
    end

    always_comb begin
        in_play    = (state_q == PLAY);
        hit_edge   = bus.hit & ~hit_prev_q;
        scored     = in_play & armed_q & hit_edge & ~bus.start;
        missed     = in_play & armed_q & bus.note_pass & ~scored & ~bus.start;
        drain      = (pending_q != 4'd0) && (state_q != IDLE);
        combo_next = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
        mult_new   = mult_of(combo_next, COMBO_T1, COMBO_T2, COMBO_T3);
        pend_add   = scored ? {2'b00, mult_new} : 5'd0;
        pend_sum   = {1'b0, pending_q} - {4'b0000, drain} + pend_add;
    end

    // Pending credit is spent one point per cycle so the score visibly counts up.
    always_comb begin
        armed_d   = armed_q;
        combo_d   = combo_q;
        best_d    = best_q;
        miss_d    = miss_q;
        pending_d = pending_q;
        score_d   = score_q;
        flash_d   = (flash_q != 24'd0) ? flash_q - 24'd1 : flash_q;

        if (bus.start) begin
            armed_d   = 1'b1;
            combo_d   = 8'd0;
            best_d    = 8'd0;
            miss_d    = 4'd0;
            pending_d = 4'd0;
            score_d   = '0;
            flash_d   = 24'd0;
        end else begin
            pending_d = (pend_sum > 5'd15) ? 4'd15 : pend_sum[3:0];
            if (drain) score_d = score_inc;
            if (scored) begin
                combo_d = combo_next;
                best_d  = (combo_next > best_q) ? combo_next : best_q;
                flash_d = FLASH_CYCLES;
            end
            if (missed) begin
                combo_d = 8'd0;
                miss_d  = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
            end
            if (in_play && bus.note_pass) armed_d = 1'b1;
            else if (scored)              armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            hit_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            combo_q    <= 8'd0;
            best_q     <= 8'd0;
            miss_q     <= 4'd0;
            pending_q  <= 4'd0;
            score_q    <= '0;
            flash_q    <= 24'd0;
        end else begin
            hit_prev_q <= bus.hit;
            armed_q    <= armed_d;
            combo_q    <= combo_d;
            best_q     <= best_d;
            miss_q     <= miss_d;
            pending_q  <= pending_d;
            score_q    <= score_d;
            flash_q    <= flash_d;
        end
    end

    assign bus.score_bcd  = score_q;
    assign bus.combo      = combo_q;
    assign bus.best_combo = best_q;
    assign bus.mult       = mult_of(combo_q, COMBO_T1, COMBO_T2, COMBO_T3);
    assign bus.miss_count = miss_q;
    assign bus.hit_flash  = (flash_q != 24'd0);

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: a transaction-level game model queues the
// expected statistics, which are popped and compared once the DUT settles.
module tb_score_tracker;

    localparam int K_SCORE = 0;
    localparam int K_COMBO = 1;
    localparam int K_BEST  = 2;
    localparam int K_MULT  = 3;
    localparam int K_MISS  = 4;
    localparam int K_OVER  = 5;
    localparam int K_FLASH = 6;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] expv;
    } exp_t;

    logic clk = 1'b0;
    logic reset_b;
    int   testsRun = 0;
    int   testsFailed = 0;
    exp_t sb[$];

    int modelScore;
    int modelCombo;
    int modelBest;
    int modelMiss;
    bit modelArmed;
    bit modelPlaying;
    bit modelOver;

    always #5 clk = ~clk;

    score_tracker_if sif();

    score_tracker #(
        .FLASH_CYCLES (24'd5),
        .MAX_MISSES   (4'd8),
        .COMBO_T1     (8'd4),
        .COMBO_T2     (8'd8),
        .COMBO_T3     (8'd16)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (sif.slave)
    );

    function automatic int refMult(input int c);
        if (c < 4)  return 1;
        if (c < 8)  return 2;
        if (c < 16) return 3;
        return 4;
    endfunction

    function automatic logic [31:0] toBcd(input int v);
        return {20'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_SCORE: return {20'd0, sif.score_bcd};
            K_COMBO: return {24'd0, sif.combo};
            K_BEST:  return {24'd0, sif.best_combo};
            K_MULT:  return {29'd0, sif.mult};
            K_MISS:  return {28'd0, sif.miss_count};
            K_OVER:  return {31'd0, sif.game_over};
            default: return {31'd0, sif.hit_flash};
        endcase
    endfunction

    task automatic pushExp(input string tag, input int kind, input logic [31:0] v);
        sb.push_back('{tag, kind, v});
    endtask

    task automatic expectAll(input string tag);
        pushExp({tag, "_score"}, K_SCORE, toBcd(modelScore));
        pushExp({tag, "_combo"}, K_COMBO, 32'(modelCombo));
        pushExp({tag, "_best"},  K_BEST,  32'(modelBest));
        pushExp({tag, "_mult"},  K_MULT,  32'(refMult(modelCombo)));
        pushExp({tag, "_miss"},  K_MISS,  32'(modelMiss));
        pushExp({tag, "_over"},  K_OVER,  32'(modelOver));
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            testsRun++;
            assert (obs === e.expv) else begin
                testsFailed++;
                $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.expv);
            end
        end
    endtask

    task automatic applyStimulus(input logic st, input logic h, input logic np, input logic dn);
        @(negedge clk);
        sif.start     = st;
        sif.hit       = h;
        sif.note_pass = np;
        sif.done      = dn;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelStart();
        modelScore = 0; modelCombo = 0; modelBest = 0; modelMiss = 0;
        modelArmed = 1'b1; modelPlaying = 1'b1; modelOver = 1'b0;
    endtask

    task automatic modelHit();
        if (modelPlaying && modelArmed) begin
            modelArmed = 1'b0;
            if (modelCombo < 255) modelCombo++;
            if (modelCombo > modelBest) modelBest = modelCombo;
            modelScore += refMult(modelCombo);
            if (modelScore > 999) modelScore = 999;
        end
    endtask

    task automatic modelPass();
        if (modelPlaying) begin
            if (modelArmed) begin
                modelCombo = 0;
                modelMiss++;
                if (modelMiss >= 8) begin
                    modelPlaying = 1'b0;
                    modelOver    = 1'b1;
                end
            end
            modelArmed = 1'b1;
        end
    endtask

    task automatic doStart();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        modelStart();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doHit();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        modelHit();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doPass();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        modelPass();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int startScore;
        sif.start = 1'b0; sif.hit = 1'b0; sif.note_pass = 1'b0; sif.done = 1'b0;
        reset_b = 1'b0;
        modelStart();
        modelArmed = 1'b0; modelPlaying = 1'b0;

        // Reset state
        #2;
        expectAll("reset");
        pushExp("reset_flash", K_FLASH, 32'd0);
        checkOutput();
        #20 reset_b = 1'b1;

        // Three isolated hits, each followed by its note_pass
        doStart();
        for (int i = 0; i < 3; i++) begin
            doHit();
            doPass();
        end
        idle(4);
        expectAll("three_hits");
        checkOutput();

        // Restart, first-hit timing and flash length
        doStart();
        startScore = modelScore;
        doHit();
        pushExp("hit_combo_at_N", K_COMBO, 32'd1);
        pushExp("hit_score_at_N", K_SCORE, toBcd(startScore));
        pushExp("flash_rise", K_FLASH, 32'd1);
        checkOutput();
        idle(1);
        pushExp("score_at_N1", K_SCORE, toBcd(1));
        checkOutput();
        idle(3);
        pushExp("flash_last", K_FLASH, 32'd1);
        checkOutput();
        idle(1);
        pushExp("flash_fall", K_FLASH, 32'd0);
        checkOutput();
        doPass();
        for (int i = 0; i < 4; i++) begin
            doHit();
            doPass();
        end
        idle(4);
        expectAll("five_hits");
        checkOutput();
        doPass();
        idle(2);
        expectAll("first_miss");
        checkOutput();

        // Held hit level and a second edge on the same note score once
        doStart();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        modelHit();
        idle(9);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        modelHit();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        doPass();
        idle(3);
        expectAll("held_hit");
        checkOutput();

        // Hit edge coincident with note_pass: scores, no miss, stays armed
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        modelHit();
        modelPass();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        expectAll("hit_and_pass");
        checkOutput();
        doHit();
        doPass();
        idle(3);
        expectAll("rearmed");
        checkOutput();

        // done ends the game; done together with start restarts
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        modelPlaying = 1'b0;
        modelOver    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("done");
        checkOutput();
        doHit();
        idle(2);
        expectAll("over_ignores_hit");
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        modelStart();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("start_beats_done");
        checkOutput();

        // Eight misses end the game one edge later
        for (int i = 0; i < 8; i++) doPass();
        pushExp("miss8_count", K_MISS, 32'd8);
        pushExp("miss8_not_over_yet", K_OVER, 32'd0);
        checkOutput();
        idle(1);
        expectAll("game_over");
        checkOutput();
        doHit();
        doHit();
        idle(4);
        expectAll("over_frozen");
        checkOutput();

        // Score saturation at 999 via long x4 combo (combo saturates at 255 too)
        doStart();
        for (int i = 0; i < 256; i++) begin
            doHit();
            doPass();
        end
        idle(6);
        expectAll("saturate");
        checkOutput();

        // Asynchronous reset in the middle of a drain
        doHit();
        #2 reset_b = 1'b0;
        #1;
        modelStart();
        modelArmed = 1'b0; modelPlaying = 1'b0;
        expectAll("async_reset");
        pushExp("async_reset_flash", K_FLASH, 32'd0);
        checkOutput();
        idle(3);
        reset_b = 1'b1;
        idle(6);
        pushExp("post_reset_score", K_SCORE, toBcd(0));
        pushExp("post_reset_over", K_OVER, 32'd0);
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
